// File: rtl/knight_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : knight_move_ctrl
// Purpose : Knight movement sequencer for the 11x11 tile map, covering target
//           read, outcome decode, tile write-back and a frame-based cooldown.
// Rev     : 1.0  initial release
// ============================================================================
module knight_move_ctrl #(
  parameter logic [3:0]  START_X       = 4'd5,
  parameter logic [3:0]  START_Y       = 4'd10,
  parameter logic [3:0]  GRID_MAX      = 4'd10,
  parameter logic [7:0]  FLOOR_ID      = 8'd0,
  parameter logic [7:0]  WALL_ID       = 8'd1,
  parameter logic [7:0]  KEY_ID        = 8'd2,
  parameter logic [7:0]  DOOR_ID       = 8'd3,
  parameter logic [7:0]  STAIR_ID      = 8'd4,
  parameter int unsigned MOVE_COOLDOWN = 4
) (
  input  logic       CLK,
  input  logic       RESET_H,
  input  logic       FRAME_CLK,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  output logic       move_ack,
  output logic       busy,
  output logic       map_rd_en,
  output logic [3:0] map_rd_x,
  output logic [3:0] map_rd_y,
  input  logic [7:0] map_rd_data,
  output logic       map_wr_en,
  output logic [3:0] map_wr_x,
  output logic [3:0] map_wr_y,
  output logic [7:0] map_wr_data,
  output logic [3:0] KnightX,
  output logic [3:0] KnightY,
  output logic [3:0] key_count,
  output logic       move_blocked,
  output logic       floor_up
);

  localparam logic [3:0] c_cool_last = 4'(MOVE_COOLDOWN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_DEC  = 3'd2,
    S_WR   = 3'd3,
    S_COOL = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_tgt_x;
  logic [3:0] r_tgt_y;
  logic [3:0] r_cool_cnt;
  logic       r_frame_q;
  logic       r_frame_d;
  logic       w_frame_tick;
  logic [3:0] w_tgt_x;
  logic [3:0] w_tgt_y;
  logic       w_oob;
  logic       w_accept;
  logic       w_dec_move;
  logic       w_dec_key_inc;
  logic       w_dec_key_dec;
  logic       w_dec_block;
  logic       w_dec_stair;

  assign w_frame_tick = r_frame_q & ~r_frame_d;

  // Target is latched even when out of bounds, but the wrapped value is never
  // read or written because an out-of-bounds request never leaves IDLE.
  always_comb begin
    w_tgt_x = KnightX;
    w_tgt_y = KnightY;
    w_oob   = 1'b0;
    case (move_dir)
      2'd0: begin
        w_oob   = (KnightY == 4'd0);
        w_tgt_y = KnightY - 4'd1;
      end
      2'd1: begin
        w_oob   = (KnightY == GRID_MAX);
        w_tgt_y = KnightY + 4'd1;
      end
      2'd2: begin
        w_oob   = (KnightX == 4'd0);
        w_tgt_x = KnightX - 4'd1;
      end
      default: begin
        w_oob   = (KnightX == GRID_MAX);
        w_tgt_x = KnightX + 4'd1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    move_ack      = 1'b0;
    map_rd_en     = 1'b0;
    map_wr_en     = 1'b0;
    w_accept      = 1'b0;
    w_dec_move    = 1'b0;
    w_dec_key_inc = 1'b0;
    w_dec_key_dec = 1'b0;
    w_dec_block   = 1'b0;
    w_dec_stair   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (move_req) begin
          move_ack = 1'b1;
          w_accept = 1'b1;
          if (!w_oob) w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        map_rd_en   = 1'b1;
        w_state_nxt = S_DEC;
      end
      S_DEC: begin
        if (map_rd_data == FLOOR_ID) begin
          w_dec_move  = 1'b1;
          w_state_nxt = S_COOL;
        end else if (map_rd_data == KEY_ID) begin
          w_dec_move    = 1'b1;
          w_dec_key_inc = 1'b1;
          w_state_nxt   = S_WR;
        end else if ((map_rd_data == DOOR_ID) && (key_count != 4'd0)) begin
          w_dec_move    = 1'b1;
          w_dec_key_dec = 1'b1;
          w_state_nxt   = S_WR;
        end else if (map_rd_data == STAIR_ID) begin
          w_dec_stair = 1'b1;
          w_state_nxt = S_COOL;
        end else begin
          // Walls, keyless doors and anything unrecognised are refused
          w_dec_block = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        map_wr_en   = 1'b1;
        w_state_nxt = S_COOL;
      end
      S_COOL: begin
        if (w_frame_tick && (r_cool_cnt == c_cool_last)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) begin
      r_tgt_x      <= START_X;
      r_tgt_y      <= START_Y;
      KnightX      <= START_X;
      KnightY      <= START_Y;
      key_count    <= 4'd0;
      move_blocked <= 1'b0;
      floor_up     <= 1'b0;
      r_cool_cnt   <= 4'd0;
      r_frame_q    <= 1'b0;
      r_frame_d    <= 1'b0;
    end else begin
      r_frame_q    <= FRAME_CLK;
      r_frame_d    <= r_frame_q;
      move_blocked <= w_dec_block;
      floor_up     <= w_dec_stair;
      if (w_accept) begin
        r_tgt_x      <= w_tgt_x;
        r_tgt_y      <= w_tgt_y;
        move_blocked <= w_oob;
      end
      if (w_dec_move) begin
        KnightX <= r_tgt_x;
        KnightY <= r_tgt_y;
      end
      if (w_dec_key_inc && (key_count != 4'hF)) key_count <= key_count + 4'd1;
      if (w_dec_key_dec)                        key_count <= key_count - 4'd1;
      // Counter idles at zero so a tick on the COOL entry cycle is counted
      if (r_state != S_COOL)   r_cool_cnt <= 4'd0;
      else if (w_frame_tick)   r_cool_cnt <= (r_cool_cnt == c_cool_last) ? 4'd0
                                                                         : r_cool_cnt + 4'd1;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign map_rd_x    = r_tgt_x;
  assign map_rd_y    = r_tgt_y;
  assign map_wr_x    = r_tgt_x;
  assign map_wr_y    = r_tgt_y;
  assign map_wr_data = FLOOR_ID;

endmodule
`default_nettype wire

// File: tb/tb_knight_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_knight_move_ctrl
// Purpose : Directed self-checking bench for knight_move_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_knight_move_ctrl;

  localparam logic [7:0] c_floor = 8'd0;
  localparam logic [7:0] c_wall  = 8'd1;
  localparam logic [7:0] c_key   = 8'd2;
  localparam logic [7:0] c_door  = 8'd3;
  localparam logic [7:0] c_stair = 8'd4;
  localparam logic [7:0] c_junk  = 8'hEE;

  logic       CLK = 1'b0;
  logic       RESET_H;
  logic       FRAME_CLK;
  logic       move_req;
  logic [1:0] move_dir;
  logic       move_ack;
  logic       busy;
  logic       map_rd_en;
  logic [3:0] map_rd_x;
  logic [3:0] map_rd_y;
  logic [7:0] map_rd_data;
  logic       map_wr_en;
  logic [3:0] map_wr_x;
  logic [3:0] map_wr_y;
  logic [7:0] map_wr_data;
  logic [3:0] KnightX;
  logic [3:0] KnightY;
  logic [3:0] key_count;
  logic       move_blocked;
  logic       floor_up;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int ack_base;

  knight_move_ctrl dut (
    .CLK          (CLK),
    .RESET_H      (RESET_H),
    .FRAME_CLK    (FRAME_CLK),
    .move_req     (move_req),
    .move_dir     (move_dir),
    .move_ack     (move_ack),
    .busy         (busy),
    .map_rd_en    (map_rd_en),
    .map_rd_x     (map_rd_x),
    .map_rd_y     (map_rd_y),
    .map_rd_data  (map_rd_data),
    .map_wr_en    (map_wr_en),
    .map_wr_x     (map_wr_x),
    .map_wr_y     (map_wr_y),
    .map_wr_data  (map_wr_data),
    .KnightX      (KnightX),
    .KnightY      (KnightY),
    .key_count    (key_count),
    .move_blocked (move_blocked),
    .floor_up     (floor_up)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (move_ack) ack_cnt <= ack_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic frame_pulse();
    FRAME_CLK = 1'b1;
    repeat (3) tick();
    FRAME_CLK = 1'b0;
    repeat (3) tick();
  endtask

  // Issues a request in the current cycle and returns in the t+3 cycle
  task automatic move_start(input logic [1:0] dir, input logic [7:0] tile,
                            input logic [3:0] ex, input logic [3:0] ey,
                            input logic frame_at_dec, input string tag);
    move_dir = dir;
    move_req = 1'b1;
    #1;
    chk({tag, ":ack"}, 16'(move_ack), 16'd1);
    tick();
    move_req = 1'b0;
    chk({tag, ":rd_en"}, 16'(map_rd_en), 16'd1);
    chk({tag, ":rd_xy"}, {8'd0, map_rd_x, map_rd_y}, {8'd0, ex, ey});
    tick();
    chk({tag, ":rd_en_low"}, 16'(map_rd_en), 16'd0);
    map_rd_data = tile;
    if (frame_at_dec) FRAME_CLK = 1'b1;
    tick();
    map_rd_data = c_junk;
  endtask

  initial begin
    RESET_H     = 1'b1;
    FRAME_CLK   = 1'b0;
    move_req    = 1'b0;
    move_dir    = 2'd0;
    map_rd_data = c_junk;
    repeat (3) tick();
    RESET_H = 1'b0;
    repeat (20) tick();

    chk("rst_pos",     {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd10});
    chk("rst_keys",    16'(key_count), 16'd0);
    chk("rst_busy",    16'(busy), 16'd0);
    chk("rst_strobes", 16'({move_ack, map_rd_en, map_wr_en, move_blocked, floor_up}), 16'd0);

    // Down from the bottom row is out of bounds
    move_dir = 2'd1;
    move_req = 1'b1;
    #1;
    chk("oob:ack", 16'(move_ack), 16'd1);
    tick();
    move_req = 1'b0;
    chk("oob:blocked", 16'(move_blocked), 16'd1);
    chk("oob:rd_en",   16'(map_rd_en), 16'd0);
    chk("oob:busy",    16'(busy), 16'd0);
    chk("oob:pos",     {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd10});
    tick();
    chk("oob:blk_pulse", 16'(move_blocked), 16'd0);

    // Plain floor step up, then a four-tick cooldown
    move_start(2'd0, c_floor, 4'd5, 4'd9, 1'b0, "flr");
    chk("flr:pos",   {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd9});
    chk("flr:wr_en", 16'(map_wr_en), 16'd0);
    chk("flr:busy",  16'(busy), 16'd1);
    repeat (3) frame_pulse();
    chk("flr:busy_3ticks", 16'(busy), 16'd1);
    frame_pulse();
    chk("flr:busy_4ticks", 16'(busy), 16'd0);

    RESET_H = 1'b1;
    #1;
    chk("rst2:pos", {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd10});
    tick();
    RESET_H = 1'b0;
    tick();

    move_start(2'd0, c_key, 4'd5, 4'd9, 1'b0, "key");
    chk("key:pos",     {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd9});
    chk("key:count",   16'(key_count), 16'd1);
    chk("key:wr_en",   16'(map_wr_en), 16'd1);
    chk("key:wr_xy",   {8'd0, map_wr_x, map_wr_y}, {8'd0, 4'd5, 4'd9});
    chk("key:wr_data", 16'(map_wr_data), 16'(c_floor));
    tick();
    chk("key:wr_pulse", 16'(map_wr_en), 16'd0);
    repeat (4) frame_pulse();
    chk("key:idle", 16'(busy), 16'd0);

    move_start(2'd0, c_door, 4'd5, 4'd8, 1'b0, "door");
    chk("door:pos",     {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd8});
    chk("door:count",   16'(key_count), 16'd0);
    chk("door:wr_en",   16'(map_wr_en), 16'd1);
    chk("door:wr_xy",   {8'd0, map_wr_x, map_wr_y}, {8'd0, 4'd5, 4'd8});
    chk("door:wr_data", 16'(map_wr_data), 16'(c_floor));
    tick();
    repeat (4) frame_pulse();
    chk("door:idle", 16'(busy), 16'd0);

    // Keyless door then wall: refused, no write, no cooldown
    move_start(2'd0, c_door, 4'd5, 4'd7, 1'b0, "dr0");
    chk("dr0:blocked", 16'(move_blocked), 16'd1);
    chk("dr0:wr_en",   16'(map_wr_en), 16'd0);
    chk("dr0:busy",    16'(busy), 16'd0);
    chk("dr0:pos",     {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd8});
    move_start(2'd0, c_wall, 4'd5, 4'd7, 1'b0, "wall");
    chk("wall:blocked", 16'(move_blocked), 16'd1);
    chk("wall:wr_en",   16'(map_wr_en), 16'd0);
    chk("wall:busy",    16'(busy), 16'd0);
    chk("wall:pos",     {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd8});
    tick();
    chk("wall:blk_pulse", 16'(move_blocked), 16'd0);

    // Stair with a frame tick landing on the COOL entry cycle
    move_start(2'd0, c_stair, 4'd5, 4'd7, 1'b1, "stair");
    FRAME_CLK = 1'b0;
    chk("stair:floor_up", 16'(floor_up), 16'd1);
    chk("stair:pos",      {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd8});
    chk("stair:wr_en",    16'(map_wr_en), 16'd0);
    chk("stair:busy",     16'(busy), 16'd1);
    tick();
    chk("stair:fu_pulse", 16'(floor_up), 16'd0);
    repeat (3) frame_pulse();
    chk("stair:entry_tick", 16'(busy), 16'd0);

    // Held request, 100-CLK frames: acks at c, c+402, c+802 within 1200 cycles
    map_rd_data = c_floor;
    move_dir    = 2'd0;
    ack_base    = ack_cnt;
    move_req    = 1'b1;
    for (int f = 0; f < 12; f++) begin
      FRAME_CLK = 1'b1;
      repeat (50) tick();
      FRAME_CLK = 1'b0;
      repeat (50) tick();
    end
    move_req = 1'b0;
    chk("hold:acks", 16'(ack_cnt - ack_base), 16'd3);
    chk("hold:pos",  {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd5});
    chk("hold:busy", 16'(busy), 16'd1);
    map_rd_data = c_junk;

    RESET_H = 1'b1;
    tick();
    RESET_H = 1'b0;
    tick();

    // Reset asserted in the middle of the write cycle
    move_start(2'd0, c_key, 4'd5, 4'd9, 1'b0, "rwr");
    chk("rwr:wr_en", 16'(map_wr_en), 16'd1);
    RESET_H = 1'b1;
    #1;
    chk("rwr:wr_drop", 16'(map_wr_en), 16'd0);
    chk("rwr:pos",     {8'd0, KnightX, KnightY}, {8'd0, 4'd5, 4'd10});
    chk("rwr:keys",    16'(key_count), 16'd0);
    chk("rwr:busy",    16'(busy), 16'd0);
    tick();
    RESET_H = 1'b0;
    tick();
    chk("rwr:after", 16'({busy, map_wr_en, map_rd_en}), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
